// File: rtl/btb_resolve.sv
// btb_resolve: pairs fetch-time BTB predictions with ID-stage branch resolution.
// Issues BTB maintenance commands and an IF redirect one cycle after each resolution.
module btb_resolve #(
  parameter int DEPTH = 4,
  parameter int IDXW  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            pred_valid,
  output logic            pred_ready,
  input  logic [31:0]     pred_pc,
  input  logic            pred_hit,
  input  logic            pred_taken,
  input  logic [31:0]     pred_target,
  input  logic [IDXW-1:0] pred_index,
  input  logic            br_valid,
  input  logic [31:0]     br_pc,
  input  logic            br_is_cf,
  input  logic            br_is_call,
  input  logic            br_is_ret,
  input  logic            br_taken,
  input  logic [31:0]     br_target,
  output logic            operate_en,
  output logic [31:0]     operate_pc,
  output logic [IDXW-1:0] operate_index,
  output logic            push_ras,
  output logic            pop_ras,
  output logic            add_entry,
  output logic            delete_entry,
  output logic            pre_error,
  output logic            pre_right,
  output logic            target_error,
  output logic            right_orien,
  output logic [31:0]     right_target,
  output logic            redirect_en,
  output logic [31:0]     redirect_pc,
  output logic [31:0]     cnt_cf,
  output logic [31:0]     cnt_mispred
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0]     pc;
    logic            hit;
    logic            taken;
    logic [31:0]     target;
    logic [IDXW-1:0] index;
  } pred_t;

  typedef struct packed {
    logic            op_en, push_ras, pop_ras, add, del, perr, pright, terr, orien, redir;
    logic [31:0]     op_pc;
    logic [IDXW-1:0] op_idx;
    logic [31:0]     rtgt;
    logic [31:0]     rpc;
  } upd_t;

  pred_t           mem_q [DEPTH];
  pred_t           mem_d [DEPTH];
  logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]     cnt_q, cnt_d;
  upd_t            upd_q, upd_d;
  logic [31:0]     cnt_cf_q, cnt_cf_d, cnt_mis_q, cnt_mis_d;

  pred_t       head;
  logic        res, nonempty, usable, h_hit, h_taken, mispred, pop, push, clr;
  logic [31:0] seq, pnext, anext;

  assign pred_ready = (cnt_q != FULL_CNT);
  assign head       = mem_q[rp_q];

  // Head pairing, next-pc comparison and queue pointer/count update.
  always_comb begin
    res      = br_valid & ~flush;
    nonempty = (cnt_q != '0);
    usable   = nonempty & (head.pc == br_pc);
    h_hit    = usable & head.hit;
    h_taken  = usable & head.taken;
    seq      = br_pc + 32'd4;
    pnext    = (h_hit & h_taken) ? head.target : seq;
    anext    = (br_is_cf & br_taken) ? br_target : seq;
    mispred  = (pnext != anext);
    pop      = res & usable;
    // a full queue may still accept when the head leaves in the same cycle
    push     = pred_valid & (pred_ready | pop);
    // stale head or mispredict means everything queued is wrong-path
    clr      = flush | (res & (mispred | (nonempty & ~usable)));
    mem_d    = mem_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wp_q] = '{pc: pred_pc, hit: pred_hit, taken: pred_taken,
                        target: pred_target, index: pred_index};
        wp_d = wp_q + 1'b1;
      end
      if (pop) rp_d = rp_q + 1'b1;
      cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // BTB command decision (first match wins) and saturating statistics.
  always_comb begin
    upd_d     = '0;
    cnt_cf_d  = cnt_cf_q;
    cnt_mis_d = cnt_mis_q;
    if (res) begin
      upd_d.op_pc    = br_pc;
      upd_d.op_idx   = usable ? head.index : '0;
      upd_d.rtgt     = br_target;
      upd_d.orien    = br_taken;
      upd_d.push_ras = br_is_cf & br_is_call;
      upd_d.pop_ras  = br_is_cf & br_is_ret;
      if (!br_is_cf && h_hit)                 upd_d.del  = 1'b1;
      else if (br_is_cf && !h_hit && br_taken) upd_d.add  = 1'b1;
      else if (br_is_cf && h_hit && br_taken && head.target != br_target && !br_is_ret)
                                               upd_d.terr = 1'b1;
      else if (br_is_cf && h_hit) begin
        if (h_taken == br_taken) upd_d.pright = 1'b1;
        else                     upd_d.perr   = 1'b1;
      end
      upd_d.op_en = upd_d.del | upd_d.add | upd_d.terr | upd_d.pright | upd_d.perr |
                    upd_d.push_ras | upd_d.pop_ras;
      upd_d.redir = mispred;
      upd_d.rpc   = anext;
      cnt_cf_d    = cnt_cf_q  + {31'd0, br_is_cf & ~(&cnt_cf_q)};
      cnt_mis_d   = cnt_mis_q + {31'd0, mispred  & ~(&cnt_mis_q)};
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      upd_q     <= '0;
      cnt_cf_q  <= '0;
      cnt_mis_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      upd_q     <= upd_d;
      cnt_cf_q  <= cnt_cf_d;
      cnt_mis_q <= cnt_mis_d;
    end
  end

  assign operate_en    = upd_q.op_en;
  assign operate_pc    = upd_q.op_pc;
  assign operate_index = upd_q.op_idx;
  assign push_ras      = upd_q.push_ras;
  assign pop_ras       = upd_q.pop_ras;
  assign add_entry     = upd_q.add;
  assign delete_entry  = upd_q.del;
  assign pre_error     = upd_q.perr;
  assign pre_right     = upd_q.pright;
  assign target_error  = upd_q.terr;
  assign right_orien   = upd_q.orien;
  assign right_target  = upd_q.rtgt;
  assign redirect_en   = upd_q.redir;
  assign redirect_pc   = upd_q.rpc;
  assign cnt_cf        = cnt_cf_q;
  assign cnt_mispred   = cnt_mis_q;
endmodule
